// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller:
// FSM state codes, segment patterns and the segment-to-digit reverse map.
package seven_seg_pkg;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_DEAD = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;

    // Segment order is {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SS_BLANK = 7'h00;
    localparam logic [6:0] SS_0     = 7'h7e;
    localparam logic [6:0] SS_1     = 7'h30;
    localparam logic [6:0] SS_2     = 7'h6d;
    localparam logic [6:0] SS_3     = 7'h79;
    localparam logic [6:0] SS_4     = 7'h33;
    localparam logic [6:0] SS_5     = 7'h5b;
    localparam logic [6:0] SS_6     = 7'h5f;
    localparam logic [6:0] SS_7     = 7'h70;
    localparam logic [6:0] SS_8     = 7'h7f;
    localparam logic [6:0] SS_9     = 7'h7b;

    // 4'hf means all segments off, 4'he means an unknown pattern
    function automatic logic [3:0] seven_seg_reverse(input logic [6:0] s);
        logic [3:0] d;
        case (s)
            SS_0:     d = 4'd0;
            SS_1:     d = 4'd1;
            SS_2:     d = 4'd2;
            SS_3:     d = 4'd3;
            SS_4:     d = 4'd4;
            SS_5:     d = 4'd5;
            SS_6:     d = 4'd6;
            SS_7:     d = 4'd7;
            SS_8:     d = 4'd8;
            SS_9:     d = 4'd9;
            SS_BLANK: d = 4'hf;
            default:  d = 4'he;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD to seven-segment decoder; codes above 9 give a dark digit.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SS_0;
            4'd1:    seg = SS_1;
            4'd2:    seg = SS_2;
            4'd3:    seg = SS_3;
            4'd4:    seg = SS_4;
            4'd5:    seg = SS_5;
            4'd6:    seg = SS_6;
            4'd7:    seg = SS_7;
            4'd8:    seg = SS_8;
            4'd9:    seg = SS_9;
            default: seg = SS_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-aligned loads.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int ON_CYCLES   = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int MAXC = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(DIGITS);

    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [1:0]          state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [IW-1:0]       idx, idx_n;
    logic [4*DIGITS-1:0] display, shadow;
    logic                pending;
    logic                accept, commit, last_slot;
    logic [3:0]          nib;
    logic [6:0]          dec_seg, seg_n;
    logic [DIGITS-1:0]   dig_en_n;
    logic                blank;

    assign load_ready = !pending;
    assign accept     = load_valid && load_ready;
    assign last_slot  = (state == S_ON) && (cnt == ON_LAST)
                        && (idx == IDX_LAST);
    assign frame_done = enable && last_slot;
    // While dark there is no frame to tear, so commit at once
    assign commit     = pending && (frame_done || state == S_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (commit) begin
                display <= shadow;
                pending <= 1'b0;
            end
            if (accept) begin
                shadow  <= load_value;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_OFF;
            cnt    <= '0;
            idx    <= '0;
            seg    <= SS_BLANK;
            dig_en <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            seg    <= seg_n;
            dig_en <= dig_en_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        if (!enable) begin
            state_n = S_OFF;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_n = S_DEAD;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
                S_DEAD: begin
                    if (cnt == DEAD_LAST) begin
                        state_n = S_ON;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        state_n = S_DEAD;
                        cnt_n   = '0;
                        idx_n   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = S_OFF;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    assign nib = display[{idx_n, 2'b00} +: 4];

    seven_seg_decoder u_dec (
        .bcd (nib),
        .seg (dec_seg)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz;
    logic              zero;

    // lz[i]: nibble i and everything above it are zero; digit 0 never blanks
    always_comb begin
        lz   = '0;
        zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero  = zero && (display[4*i +: 4] == 4'd0);
            lz[i] = zero;
        end
    end

    assign blank = lz[idx_n];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        dig_en_n = '0;
        seg_n    = SS_BLANK;
        if (state_n == S_ON) begin
            dig_en_n[idx_n] = 1'b1;
            seg_n           = blank ? SS_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a slot/frame arithmetic model
// predicts every cycle, a monitor pops and compares at the falling edge.
module tb_seven_seg_scan_ctrl;
    import seven_seg_pkg::*;

    localparam int DIGITS = 4;
    localparam int ON     = 4;
    localparam int DEAD   = 1;
    localparam int SL     = ON + DEAD;
    localparam int FR     = DIGITS * SL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_done;

    seven_seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .ON_CYCLES   (ON),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] de;
        logic [3:0] code;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   tmo_cnt    = 0;
    int   tmo_seen   = 0;

    // Reference model: scan position is plain arithmetic on elapsed cycles
    logic        m_scan = 1'b0;
    int          m_ph   = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_shad = 16'h0;
    logic        m_pend = 1'b0;

    function automatic logic [3:0] exp_code(input logic [15:0] d,
                                            input int slot);
        logic [3:0] n;
        n = 4'((d >> (4 * slot)) & 16'hf);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (d >> (4 * slot)) == 16'h0) return 4'hf;
`endif
        if (n > 4'd9) return 4'hf;
        return n;
    endfunction

    always @(negedge clk) begin : model
        exp_t e;
        int   f, slot, w;
        logic lit, fd, cmt, acc;
        if (!rst_n) begin
            m_scan = 1'b0;
            m_ph   = 0;
            m_disp = 16'h0;
            m_shad = 16'h0;
            m_pend = 1'b0;
            e = '{de: 4'b0, code: 4'hf, fd: 1'b0, rdy: 1'b1};
            q.push_back(e);
        end else begin
            lit  = 1'b0;
            slot = 0;
            w    = 0;
            if (m_scan) begin
                f    = m_ph % FR;
                slot = f / SL;
                w    = f % SL;
                lit  = (w >= DEAD);
            end
            fd = enable && lit && slot == DIGITS - 1 && w == SL - 1;
            e.de   = lit ? 4'(1 << slot) : 4'b0;
            e.code = lit ? exp_code(m_disp, slot) : 4'hf;
            e.fd   = fd;
            e.rdy  = !m_pend;
            q.push_back(e);
            cmt = m_pend && (!m_scan || fd);
            acc = load_valid && !m_pend;
            if (cmt) begin
                m_disp = m_shad;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_shad = load_value;
                m_pend = 1'b1;
            end
            if (!enable) begin
                m_scan = 1'b0;
            end else if (!m_scan) begin
                m_scan = 1'b1;
                m_ph   = 0;
            end else begin
                m_ph++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            if (mismatched <= 30)
                $display("FAIL %s t=%0t got=%0h want=%0h",
                         nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (clk === 1'b1) begin
                #1;
                chk("async_rst_dig_en", 32'(dig_en), 32'h0);
                chk("async_rst_seg", 32'(seg), 32'h0);
                chk("async_rst_ready", 32'(load_ready), 32'h1);
            end else if ($time > 0) begin
                #1;
                if (tmo_cnt != tmo_seen) begin
                    compared++;
                    mismatched++;
                    $display("FAIL wait_timeout t=%0t got=%0d want=%0d",
                             $time, tmo_cnt, tmo_seen);
                    tmo_seen = tmo_cnt;
                end
                if (q.size() == 0) begin
                    chk("queue_empty", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("dig_en", 32'(dig_en), 32'(e.de));
                    chk("seg_digit", 32'(seven_seg_reverse(seg)),
                        32'(e.code));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    chk("load_ready", 32'(load_ready), 32'(e.rdy));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        load_valid = 1'b1;
        load_value = v;
        step();
        load_valid = 1'b0;
    endtask

    task automatic wait_de(input logic [3:0] t, input int budget);
        int n = 0;
        while (dig_en !== t && n < budget) begin
            step();
            n++;
        end
        if (dig_en !== t) tmo_cnt++;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'h0;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = 4'($urandom_range(0, 11));
        case ($urandom_range(0, 3))
            0: v = v & 16'h00ff;
            1: v = v & 16'h000f;
            default: ;
        endcase
        return v;
    endfunction

    initial begin : stim
        step();
        step();
        rst_n = 1'b1;
        load(16'h1234);
        step();
        enable = 1'b1;
        repeat (45) step();
        wait_de(4'b0010, 30);
        load(16'h5678);
        load_valid = 1'b1;
        load_value = 16'h9999;
        repeat (60) step();
        load_valid = 1'b0;
        wait_de(4'b1000, 30);
        step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (30) step();
        load(16'h00a5);
        repeat (50) step();
        wait_de(4'b0100, 30);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) step();
        repeat (2500) begin
            load_valid = ($urandom_range(0, 2) == 0);
            load_value = rand_val();
            if (enable) begin
                if ($urandom_range(0, 149) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) enable = 1'b1;
            end
            step();
        end
        load_valid = 1'b0;
        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
